// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with majority-vote bit sampling and a one-byte holding register.
// The rx_ack handshake clears rx_avail and rx_overrun. Define UART_RX_PARITY_EN for 8E1 frames plus rx_parity_err.
module uart_rx #(
    parameter int unsigned clk_freq       = 100000000,
    parameter int unsigned uart_baud_rate = 1152000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    input  logic       rx_ack,
    output logic       rx_error,
`ifdef UART_RX_PARITY_EN
    output logic       rx_parity_err,
`endif
    output logic       rx_overrun
);

    localparam int unsigned DIV_RAW = clk_freq / (uart_baud_rate * 16);
    localparam int unsigned DIVISOR = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    samp_q, samp_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_avail_q, rx_avail_d;
    logic          rx_error_q, rx_error_d;
    logic          rx_overrun_q, rx_overrun_d;
`ifdef UART_RX_PARITY_EN
    logic          parity_err_q, parity_err_d;
`endif

    logic tick;
    logic start_edge;
    logic mid_tick;
    logic majority;
    logic load;

    assign tick       = (div_cnt_q == DW'(DIVISOR - 1));
    assign start_edge = (state_q == S_IDLE) && rxd_prev_q && !rxd_sync_q;
    assign mid_tick   = tick && (tick_cnt_q == 4'd9);
    // Third vote is the live tick-9 sample; ticks 7 and 8 were captured earlier.
    assign majority   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_sync_q) | (samp_q[1] & rxd_sync_q);

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        rx_data_d    = rx_data_q;
        rx_avail_d   = rx_avail_q;
        rx_overrun_d = rx_overrun_q;
        rx_error_d   = 1'b0;
        load         = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif

        // In BREAK the divider doubles as a "line has been high for one tick" timer.
        if (start_edge || (state_q == S_BREAK && !rxd_sync_q)) begin
            div_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
        end

        if (start_edge) begin
            tick_cnt_d = 4'd0;
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end

        if (tick && tick_cnt_q == 4'd7) begin
            samp_d[0] = rxd_sync_q;
        end
        if (tick && tick_cnt_q == 4'd8) begin
            samp_d[1] = rxd_sync_q;
        end

        // Every state advances at mid-bit, so its own tick-9 sample lands one bit period later.
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (mid_tick) begin
                    if (majority) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (mid_tick) begin
                    shift_d   = {majority, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid_tick) begin
                    parity_err_d = majority ^ (^shift_q);
                    state_d      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid_tick) begin
                    if (majority) begin
                        load    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rx_error_d = 1'b1;
                        state_d    = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (tick && rxd_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A completing byte wins over a same-cycle ack; the ack then only cancels the overrun.
        if (load) begin
            rx_data_d  = shift_q;
            rx_avail_d = 1'b1;
        end else if (rx_ack) begin
            rx_avail_d = 1'b0;
        end

        if (rx_ack) begin
            rx_overrun_d = 1'b0;
        end else if (load && rx_avail_q) begin
            rx_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            rxd_prev_q   <= 1'b1;
            div_cnt_q    <= '0;
            tick_cnt_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            samp_q       <= 2'b00;
            rx_data_q    <= 8'h00;
            rx_avail_q   <= 1'b0;
            rx_error_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rxd_meta_q   <= uart_rxd;
            rxd_sync_q   <= rxd_meta_q;
            rxd_prev_q   <= rxd_sync_q;
            div_cnt_q    <= div_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            rx_data_q    <= rx_data_d;
            rx_avail_q   <= rx_avail_d;
            rx_error_q   <= rx_error_d;
            rx_overrun_q <= rx_overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_avail   = rx_avail_q;
    assign rx_error   = rx_error_q;
    assign rx_overrun = rx_overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that deserialises 8N1 frames arriving on uart_rxd into bytes for the system core.
- Counterpart to the existing UART transmitter; sits between the uart_rxd pin and the system bus logic.
- Uses 16x oversampling from a fractional-free integer divisor and majority-vote bit sampling.
- Exposes a single-byte holding register with an avail/ack handshake plus error flags.

Parameters:
clk_freq, 100000000, system clock frequency in Hz
uart_baud_rate, 1152000, line baud rate in bit/s
(derived, localparam) divisor = clk_freq / (uart_baud_rate*16), integer truncation, minimum 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
uart_rxd  input  1  asynchronous serial line, idle high
rx_data  output  8  last received byte, LSB first on the line
rx_avail  output  1  high while rx_data holds an unacknowledged byte
rx_ack  input  1  consumer strobe; clears rx_avail
rx_error  output  1  one-cycle pulse on framing error (stop bit sampled low)
rx_overrun  output  1  sticky; a byte was overwritten before being acked

Behaviour:
- Reset: rx_data=0, rx_avail=0, rx_error=0, rx_overrun=0, state=IDLE, synchroniser flops=1, counters=0.
- Input path: 2-flop synchroniser on uart_rxd. All decisions use the synchronised value (2-cycle latency).
- Tick generator: counter 0..divisor-1; tick pulses one cycle at wrap. Runs freely; restarts at 0 on start-edge detection.
- Sampling: within each bit, a 4-bit tick counter 0..15. Samples are taken at ticks 7, 8, 9. Bit value = majority of the 3 samples.
- FSM:
  - IDLE: on synchronised falling edge (prev=1, cur=0) -> START, clear tick counter.
  - START: at tick 9 evaluate majority. 1 = false start -> IDLE, no flags. 0 -> DATA, bit index=0.
  - DATA: at tick 15 advance bit. At tick 9 shift the majority value into shift[7]; shift right, LSB first. After bit index 7 completes -> STOP.
  - STOP: at tick 9 evaluate majority.
    - 1: load rx_data<=shift, set rx_avail, -> IDLE.
    - 0: pulse rx_error for 1 cycle, discard byte, rx_avail unchanged, -> BREAK.
  - BREAK: wait until synchronised line = 1 for one full tick, then -> IDLE. Covers break conditions, so no spurious frames.
- Latency: rx_avail rises 1 clk after the stop-bit tick-9 sample.
- Handshake:
  - rx_ack while rx_avail=1 clears rx_avail next cycle.
  - rx_ack while rx_avail=0 is ignored.
  - rx_ack also clears rx_overrun.
- Overrun: a byte completes while rx_avail=1 and rx_ack=0 -> rx_data overwritten, rx_overrun<=1 (sticky until rx_ack or rst).
- Simultaneous ack and byte completion in the same cycle: new byte loaded, rx_avail stays 1, rx_overrun not set.
- Reset mid-frame: FSM returns to IDLE immediately. The partial byte is lost and no flags are raised.
- Back-to-back frames: a start edge is accepted in the first IDLE cycle after STOP, with no extra idle bits required.

Optional Feature:
UART_RX_PARITY_EN
- Defined: frame becomes 8E1. An extra PARITY state sits between DATA and STOP.
- Output rx_parity_err (1 bit) is added. It is a one-cycle pulse when the sampled parity bit ≠ XOR of the 8 data bits.
- On parity error the byte is still loaded and rx_avail set, so the consumer decides whether to drop it.
- Undefined: 8N1 only; no PARITY state and no rx_parity_err port.

Test Plan:
Defaults give divisor=5 and a bit period of 80 clk. Stimulus is driven at exactly 80 clk per bit.
1. Send 0x55, then 0xA3, separated by 2 idle bits -> rx_avail rises once per frame; rx_data=0x55 then 0xA3; rx_error=0. Ack each within 10 clk.
2. Glitch: uart_rxd low for 30 clk, then high -> false start, no rx_avail, no rx_error; the next frame 0x0F is received correctly.
3. Frame 0x7E with the stop bit held low for 80 clk, then line high -> rx_error pulses exactly 1 cycle; rx_avail stays 0. The next frame 0x81 is received.
4. Send 0x11 and 0x22 with no ack -> rx_data=0x22, rx_avail=1, rx_overrun=1. Assert rx_ack -> both flags clear the next cycle.
5. Assert rx_ack in the same cycle a second byte 0x33 completes -> rx_data=0x33, rx_avail=1, rx_overrun=0.
6. Assert rst during data bit 4 of 0xC6, release, then send 0x5A -> outputs at reset values during reset; only 0x5A is reported.
